// File: rtl/calc_pkg.sv
// Shared calculator display constants and types.
// Used by the display sequencer and the seven-segment displayer.
package calc_pkg;

   localparam int NUM_W       = 14;
   localparam int MAX_DISPLAY = 9999;

   typedef logic [NUM_W-1:0] num_t;
   typedef logic [1:0]       state_t;

   localparam state_t ST_INPUT  = 2'd0;
   localparam state_t ST_OUTPUT = 2'd1;
   localparam state_t ST_ERROR  = 2'd2;

   function automatic logic fits_display(num_t v, num_t max_v);
      return v <= max_v;
   endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter with an expiry flag at zero.
// Reusable for error hold, blink and timeout sequencing.
module hold_timer #(
   parameter  int CYCLES = 100_000_000,
   localparam int CNT_W  = $clog2(CYCLES + 1)
) (
   input  logic clock_100Mhz,
   input  logic reset,
   input  logic clear,
   input  logic load,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count;

   // Load value is CYCLES-1 so the owner sees CYCLES enabled cycles.
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (load)
         count <= CNT_W'(CYCLES - 1);
      else if (enable && count != '0)
         count <= count - 1'b1;
   end

   assign expired = enable && (count == '0);

endmodule

// File: rtl/calc_display_sequencer.sv
// Drives the displayer's state, operand, result and sign inputs
// from keypad entries and ALU results, with a timed error screen.
module calc_display_sequencer #(
   parameter int ERR_HOLD_CYCLES = 100_000_000,
   parameter int MAX_DISPLAY     = calc_pkg::MAX_DISPLAY
) (
   input  logic        clock_100Mhz,
   input  logic        reset,
   input  logic        clear,
   input  logic        entry_valid,
   input  logic [13:0] entry_number,
   input  logic        result_valid,
   output logic        result_ready,
   input  logic [13:0] result_value,
   input  logic        result_sign,
   input  logic        result_error,
   output logic [1:0]  data_state,
   output logic [13:0] input_number,
   output logic [13:0] output_number,
   output logic        sign,
   output logic        busy
);

   import calc_pkg::*;

   localparam num_t MAX_V = num_t'(MAX_DISPLAY);

   state_t state_q, state_d;
   num_t   in_q, in_d;
   num_t   out_q, out_d;
   logic   sign_q, sign_d;
   logic   busy_q;

   logic   transfer;
   logic   result_bad;
   logic   entry_ok;
   logic   t_load, t_clear, t_expired;

   assign transfer   = result_valid && result_ready;
   assign result_bad = result_error || !fits_display(result_value, MAX_V);
   assign entry_ok   = fits_display(entry_number, MAX_V);

   hold_timer #(
      .CYCLES (ERR_HOLD_CYCLES)
   ) u_hold (
      .clock_100Mhz (clock_100Mhz),
      .reset        (reset),
      .clear        (t_clear),
      .load         (t_load),
      .enable       (state_q == ST_ERROR),
      .expired      (t_expired)
   );

   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         state_q <= ST_INPUT;
         in_q    <= '0;
         out_q   <= '0;
         sign_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         in_q    <= in_d;
         out_q   <= out_d;
         sign_q  <= sign_d;
         busy_q  <= (state_d == ST_ERROR);
      end
   end

   // clear > result transfer > entry > timer expiry
   always_comb begin
      state_d = state_q;
      in_d    = in_q;
      out_d   = out_q;
      sign_d  = sign_q;
      t_load  = 1'b0;
      t_clear = 1'b0;
      if (clear) begin
         state_d = ST_INPUT;
         in_d    = '0;
         sign_d  = 1'b0;
         t_clear = 1'b1;
      end else if (transfer) begin
         if (result_bad) begin
            state_d = ST_ERROR;
            t_load  = 1'b1;
         end else begin
            state_d = ST_OUTPUT;
            out_d   = result_value;
            sign_d  = result_sign && (result_value != '0);
         end
      end else if (entry_valid && state_q != ST_ERROR) begin
         if (state_q == ST_OUTPUT) begin
            state_d = ST_INPUT;
            in_d    = entry_ok ? entry_number : '0;
         end else if (entry_ok) begin
            in_d    = entry_number;
         end
      end else if (t_expired) begin
         state_d = ST_INPUT;
         in_d    = '0;
         sign_d  = 1'b0;
      end
   end

   always_comb begin
      result_ready  = (state_q != ST_ERROR);
      data_state    = state_q;
      input_number  = in_q;
      output_number = out_q;
      sign          = sign_q;
      busy          = busy_q;
   end

endmodule

// File: tb/tb_calc_display_sequencer.sv
// Scoreboard bench for calc_display_sequencer against a
// cycle-level behavioural model of the display rules.
module tb_calc_display_sequencer;

   localparam int HOLD = 8;
   localparam int MAXD = 9999;

   logic        clock_100Mhz = 1'b0;
   logic        reset        = 1'b1;
   logic        clear        = 1'b0;
   logic        entry_valid  = 1'b0;
   logic [13:0] entry_number = '0;
   logic        result_valid = 1'b0;
   logic [13:0] result_value = '0;
   logic        result_sign  = 1'b0;
   logic        result_error = 1'b0;
   logic        result_ready;
   logic [1:0]  data_state;
   logic [13:0] input_number;
   logic [13:0] output_number;
   logic        sign;
   logic        busy;

   calc_display_sequencer #(
      .ERR_HOLD_CYCLES (HOLD),
      .MAX_DISPLAY     (MAXD)
   ) dut (
      .clock_100Mhz  (clock_100Mhz),
      .reset         (reset),
      .clear         (clear),
      .entry_valid   (entry_valid),
      .entry_number  (entry_number),
      .result_valid  (result_valid),
      .result_ready  (result_ready),
      .result_value  (result_value),
      .result_sign   (result_sign),
      .result_error  (result_error),
      .data_state    (data_state),
      .input_number  (input_number),
      .output_number (output_number),
      .sign          (sign),
      .busy          (busy)
   );

   always #5 clock_100Mhz = ~clock_100Mhz;

   typedef struct {
      int st;
      int inn;
      int outn;
      int sg;
      int bz;
      int rdy;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   // Model: mode 0 input, 1 output, 2 error; left = error cycles still to show
   int m_mode, m_in, m_out, m_sign, m_left;
   bit m_acc;

   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_in = 0; m_out = 0; m_sign = 0; m_left = 0;
   endtask

   task automatic model_step();
      bit rdy;
      rdy   = (m_mode != 2);
      m_acc = 0;
      if (clear) begin
         m_mode = 0; m_in = 0; m_sign = 0; m_left = 0;
      end else if (result_valid && rdy) begin
         m_acc = 1;
         if (result_error || int'(result_value) > MAXD) begin
            m_mode = 2;
            m_left = HOLD;
         end else begin
            m_mode = 1;
            m_out  = int'(result_value);
            m_sign = (result_sign && result_value != 0) ? 1 : 0;
         end
      end else if (entry_valid && m_mode != 2) begin
         if (m_mode == 1) begin
            m_mode = 0;
            m_in   = (int'(entry_number) <= MAXD) ? int'(entry_number) : 0;
         end else if (int'(entry_number) <= MAXD) begin
            m_in = int'(entry_number);
         end
      end else if (m_mode == 2) begin
         m_left--;
         if (m_left == 0) begin
            m_mode = 0; m_in = 0; m_sign = 0;
         end
      end
   endtask

   task automatic cycle();
      exp_t e;
      @(posedge clock_100Mhz);
      #1;
      model_step();
      e.st   = m_mode;
      e.inn  = m_in;
      e.outn = m_out;
      e.sg   = m_sign;
      e.bz   = (m_mode == 2) ? 1 : 0;
      e.rdy  = (m_mode != 2) ? 1 : 0;
      sbq.push_back(e);
   endtask

   task automatic drive(input bit c, input bit ev, input logic [13:0] en,
                        input bit rv, input logic [13:0] rval,
                        input bit rs, input bit re);
      clear        = c;
      entry_valid  = ev;
      entry_number = en;
      result_valid = rv;
      result_value = rval;
      result_sign  = rs;
      result_error = re;
      cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge clock_100Mhz) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("data_state",    32'(data_state),    e.st);
         chk("input_number",  32'(input_number),  e.inn);
         chk("output_number", 32'(output_number), e.outn);
         chk("sign",          32'(sign),          e.sg);
         chk("busy",          32'(busy),          e.bz);
         chk("result_ready",  32'(result_ready),  e.rdy);
      end
   end

   function automatic logic [13:0] pick_val();
      case ($urandom_range(0, 5))
         0:       return 14'd0;
         1:       return 14'd9999;
         2:       return 14'd10000;
         3:       return 14'd16383;
         default: return 14'($urandom_range(0, 9999));
      endcase
   endfunction

   task automatic check_reset_values(string tag);
      chk({tag, "_state"},  32'(data_state),    0);
      chk({tag, "_in"},     32'(input_number),  0);
      chk({tag, "_out"},    32'(output_number), 0);
      chk({tag, "_sign"},   32'(sign),          0);
      chk({tag, "_busy"},   32'(busy),          0);
      chk({tag, "_ready"},  32'(result_ready),  1);
      chk({tag, "_count"},  32'(dut.u_hold.count), 0);
   endtask

   initial begin
      bit          pend;
      logic [13:0] pv;
      bit          ps, pe;
      int          guard;

      model_reset();
      #2;
      check_reset_values("rst");
      @(negedge clock_100Mhz);
      reset = 1'b0;

      // directed walk through the main use cases
      drive(0, 1, 14'd1234, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 14'd567, 1, 0);
      drive(0, 1, 14'd8, 0, 0, 0, 0);
      drive(0, 1, 14'd12000, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 14'd12000, 0, 0);
      idle(HOLD + 2);
      drive(0, 0, 0, 1, 14'd0, 1, 0);
      drive(0, 0, 0, 1, 14'd5, 0, 1);
      drive(0, 1, 14'd33, 1, 14'd42, 1, 0);
      guard = 0;
      while (!m_acc && guard < 3 * HOLD) begin
         drive(0, 0, 0, 1, 14'd42, 1, 0);
         guard++;
      end
      chk("pending_result_accepted", 32'(m_acc), 1);
      drive(0, 1, 14'd16000, 0, 0, 0, 0);
      drive(1, 1, 14'd77, 1, 14'd300, 0, 0);
      drive(0, 0, 0, 1, 14'd300, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);

      // reset three cycles into the error hold
      drive(0, 0, 0, 1, 14'd5, 0, 1);
      idle(3);
      @(negedge clock_100Mhz);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("midhold");
      model_reset();
      @(negedge clock_100Mhz);
      #2;
      reset = 1'b0;
      chk("post_reset_count", 32'(dut.u_hold.count), 0);
      idle(HOLD + 4);

      // constrained-random traffic with a valid-holding result source
      pend = 0; pv = '0; ps = 0; pe = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!pend && $urandom_range(0, 3) == 0) begin
            pend = 1;
            pv   = pick_val();
            ps   = 1'($urandom_range(0, 1));
            pe   = ($urandom_range(0, 7) == 0);
         end
         drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0),
               pick_val(), pend, pv, ps, pe);
         if (m_acc) pend = 0;
      end
      idle(1);
      @(negedge clock_100Mhz);
      #1;
      chk("scoreboard_drained", 32'(sbq.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
